// File: rtl/sccb_config_seq_pkg.sv
// Shared camera constants: SCCB table codes, sensor IDs
// and the FSM encodings used by the config sequencer.
package sccb_config_seq_pkg;

  localparam logic [15:0] SCCB_END     = 16'hFFFF;
  localparam logic [7:0]  SCCB_DLY_PFX = 8'hF0;
  localparam logic [7:0]  OV_ID_WR     = 8'h42;
  localparam logic [7:0]  OV_COM7      = 8'h12;
  localparam logic [7:0]  COM7_RESET   = 8'h80;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_DELAY  = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  localparam logic [1:0] P_IDLE  = 2'd0;
  localparam logic [1:0] P_START = 2'd1;
  localparam logic [1:0] P_BITS  = 2'd2;
  localparam logic [1:0] P_STOP  = 2'd3;

  typedef struct packed {
    logic [7:0] ra;
    logic [7:0] val;
  } sccb_entry_t;

  // Bits 8, 17 and 26 are the ACK slots of each 9-bit phase.
  function automatic logic dc_bit(input logic [4:0] b);
    return (b == 5'd8) || (b == 5'd17) || (b == 5'd26);
  endfunction

endpackage

// File: rtl/sccb_config_seq_write_phy.sv
// SCCB 3-phase write engine: start, 27 bits in 4Q slots,
// stop; wr_done fires in the last cycle of the stop.
module sccb_write_phy
  import sccb_config_seq_pkg::*;
#(
  parameter int CLK_HZ  = 10_000_000,
  parameter int SCCB_HZ = 100_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       go,
  input  logic [7:0] id,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  output logic       wr_done,
  output logic       sioc,
  output logic       siod_out,
  output logic       siod_oe
);

  localparam int QR = CLK_HZ / (4 * SCCB_HZ);
  localparam int Q  = (QR < 1) ? 1 : QR;
  localparam int QW = $clog2(Q + 1);

  logic [QW-1:0] qcnt;
  logic [1:0]    phase;
  logic [1:0]    qi;
  logic [4:0]    bitn;
  logic [26:0]   sh;
  logic          tick;

  assign tick = (qcnt == QW'(Q - 1));
  assign wr_done = (phase == P_STOP) && (qi == 2'd3) && tick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase    <= P_IDLE;
      qcnt     <= '0;
      qi       <= 2'd0;
      bitn     <= 5'd0;
      sh       <= '0;
      sioc     <= 1'b1;
      siod_out <= 1'b1;
      siod_oe  <= 1'b1;
    end else begin
      qcnt <= (phase == P_IDLE || tick) ? '0 : qcnt + 1'b1;
      if (tick && phase != P_IDLE)
        qi <= qi + 2'd1;
      unique case (phase)
        P_IDLE: begin
          if (go) begin
            phase    <= P_START;
            qi       <= 2'd0;
            sh       <= {id, 1'b1, addr, 1'b1, data, 1'b1};
            sioc     <= 1'b1;
            siod_out <= 1'b0;
            siod_oe  <= 1'b1;
          end
        end
        P_START: begin
          if (tick && qi == 2'd1) begin
            phase    <= P_BITS;
            qi       <= 2'd0;
            bitn     <= 5'd0;
            sioc     <= 1'b0;
            siod_out <= sh[26];
          end
        end
        P_BITS: begin
          if (tick) begin
            unique case (qi)
              2'd0: sioc <= 1'b1;
              2'd2: sioc <= 1'b0;
              2'd3: begin
                if (bitn == 5'd26) begin
                  phase    <= P_STOP;
                  siod_out <= 1'b0;
                  siod_oe  <= 1'b1;
                end else begin
                  bitn     <= bitn + 5'd1;
                  sh       <= {sh[25:0], 1'b0};
                  siod_out <= sh[25];
                  siod_oe  <= !dc_bit(bitn + 5'd1);
                end
              end
              default: ;
            endcase
          end
        end
        P_STOP: begin
          if (tick) begin
            unique case (qi)
              2'd0: sioc <= 1'b1;
              2'd2: siod_out <= 1'b1;
              2'd3: phase <= P_IDLE;
              default: ;
            endcase
          end
        end
        default: phase <= P_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sccb_config_seq.sv
// Boot-time sensor config: walks a ROM table of SCCB writes
// and ms waits, pulsing done when the table is exhausted.
module sccb_config_seq
  import sccb_config_seq_pkg::*;
#(
  parameter int         CLK_HZ  = 10_000_000,
  parameter int         SCCB_HZ = 100_000,
  parameter logic [7:0] DEV_ID  = OV_ID_WR,
  parameter int         ROM_AW  = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              busy,
  output logic              done,
  output logic [7:0]        writes,
  output logic              sioc,
  output logic              siod_out,
  output logic              siod_oe
);

  localparam int MS  = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
  localparam int MSW = $clog2(MS + 1);

  logic [2:0]     state;
  logic [7:0]     ms_left;
  logic [MSW-1:0] cyc;
  sccb_entry_t    ent;
  logic           is_end;
  logic           is_dly;
  logic           go;
  logic           wr_done;
  logic           ms_end;
  logic           adv;

  assign ent    = rom_data;
  assign is_end = (rom_data == SCCB_END);
  assign is_dly = (ent.ra == SCCB_DLY_PFX);
  assign go     = (state == S_DECODE) && !is_end && !is_dly;
  assign ms_end = (cyc == MSW'(MS - 1));

  // Any finished entry moves on; a zero-length wait costs nothing.
  assign adv =
    ((state == S_DECODE) && is_dly && ent.val == 8'd0) ||
    ((state == S_WRITE) && wr_done) ||
    ((state == S_DELAY) && ms_end && ms_left == 8'd1);

  sccb_write_phy #(
    .CLK_HZ  (CLK_HZ),
    .SCCB_HZ (SCCB_HZ)
  ) u_phy (
    .clk      (clk),
    .reset_n  (reset_n),
    .go       (go),
    .id       (DEV_ID),
    .addr     (ent.ra),
    .data     (ent.val),
    .wr_done  (wr_done),
    .sioc     (sioc),
    .siod_out (siod_out),
    .siod_oe  (siod_oe)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      rom_addr <= '0;
      writes   <= 8'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ms_left  <= 8'd0;
      cyc      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            rom_addr <= '0;
            writes   <= 8'd0;
            busy     <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          unique case (1'b1)
            is_end: begin
              state <= S_FINISH;
              done  <= 1'b1;
            end
            is_dly: begin
              if (ent.val != 8'd0) begin
                ms_left <= ent.val;
                cyc     <= '0;
                state   <= S_DELAY;
              end
            end
            default: state <= S_WRITE;
          endcase
        end
        S_WRITE: begin
          if (wr_done && writes != 8'hFF)
            writes <= writes + 8'd1;
        end
        S_DELAY: begin
          if (ms_end) begin
            cyc     <= '0;
            ms_left <= ms_left - 8'd1;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // Table end without a marker finishes instead of wrapping.
      if (adv) begin
        if (&rom_addr) begin
          state <= S_FINISH;
          done  <= 1'b1;
        end else begin
          rom_addr <= rom_addr + 1'b1;
          state    <= S_FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_sccb_config_seq.sv
// Bench for sccb_config_seq: ROM tables, bus monitor decoding
// frames, and a table-level reference model.
module tb_sccb_config_seq;
  import sccb_config_seq_pkg::*;

  localparam int CLK_HZ  = 1_000_000;
  localparam int SCCB_HZ = 125_000;
  localparam int Q  = CLK_HZ / (4 * SCCB_HZ);
  localparam int W  = 114 * Q;
  localparam int MS = CLK_HZ / 1000;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [5:0]  rom_addr;
  logic [15:0] rom_data;
  logic        busy;
  logic        done;
  logic [7:0]  writes;
  logic        sioc;
  logic        siod_out;
  logic        siod_oe;

  sccb_config_seq #(
    .CLK_HZ  (CLK_HZ),
    .SCCB_HZ (SCCB_HZ),
    .DEV_ID  (8'h42),
    .ROM_AW  (6)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .busy     (busy),
    .done     (done),
    .writes   (writes),
    .sioc     (sioc),
    .siod_out (siod_out),
    .siod_oe  (siod_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] rom [64];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act,
                         input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d",
               nm, act, lo, hi);
    end
  endtask

  // Bus monitor: decodes frames and checks the waveform rules.
  logic [23:0] mon_q[$];
  logic [23:0] exp_q[$];
  int          gap_q[$];
  logic [26:0] mon_sh;
  bit          mon_in = 0;
  int          mon_bit = 0;
  int          hcnt = 0;
  int          sioc_edges = 0;
  int          stop_cyc = -1;
  logic        psioc = 1'b1;
  logic        psiod = 1'b1;

  always @(negedge clk) begin
    if (!reset_n) begin
      mon_in = 0;
      mon_bit = 0;
      hcnt = 0;
      psioc = 1'b1;
      psiod = 1'b1;
    end else begin
      if (psioc && sioc && psiod !== siod_out) begin
        if (!mon_in && !siod_out) begin
          mon_in = 1;
          mon_bit = 0;
          if (stop_cyc >= 0) gap_q.push_back(cyc_n - stop_cyc);
        end else if (mon_in && mon_bit == 27 && siod_out) begin
          mon_in = 0;
          stop_cyc = cyc_n;
          mon_q.push_back({mon_sh[26:19], mon_sh[17:10],
                           mon_sh[8:1]});
        end else begin
          chk("siod_hold_sioc_high", siod_out, psiod);
        end
      end
      if (!psioc && sioc) begin
        sioc_edges++;
        if (mon_in && mon_bit < 27) begin
          mon_sh = {mon_sh[25:0], siod_out};
          chk($sformatf("oe_bit%0d", mon_bit + 1), siod_oe,
              !(mon_bit == 8 || mon_bit == 17 || mon_bit == 26));
          mon_bit++;
          hcnt = 1;
        end
      end else if (psioc && sioc && hcnt > 0) begin
        hcnt++;
      end
      if (psioc && !sioc) begin
        sioc_edges++;
        if (hcnt > 0) chk("sioc_high_len", hcnt, 2 * Q);
        hcnt = 0;
      end
      psioc = sioc;
      psiod = siod_out;
    end
  end

  // Reference: walk the table by its decode rules.
  task automatic model(output int nw, output int lat);
    logic [15:0] e;
    nw = 0;
    lat = 0;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      e = rom[i];
      if (e == 16'hFFFF) begin
        lat += 3;
        return;
      end
      if (e[15:8] == 8'hF0) begin
        lat += int'(e[7:0]) * MS + 2;
      end else begin
        exp_q.push_back({8'h42, e});
        nw++;
        lat += W + 2;
      end
    end
    lat += 1;
  endtask

  task automatic run_table(input string nm, input int exp_w,
                           input int exp_lat, input bit extra);
    int cnt;
    int e0;
    bit nz;
    bit wrapped;
    mon_q.delete();
    gap_q.delete();
    stop_cyc = -1;
    nz = 0;
    wrapped = 0;
    e0 = sioc_edges;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cnt = 1;
    while (!done && cnt < exp_lat + 300) begin
      if (rom_addr != 6'd0) nz = 1;
      else if (nz) wrapped = 1;
      start = extra && (cnt == 40 || cnt == exp_lat / 2);
      @(posedge clk); #1;
      cnt++;
    end
    start = 1'b0;
    chk({nm, " done"}, done, 1);
    chk_rng({nm, " latency"}, cnt, exp_lat - exp_w,
            exp_lat + exp_w);
    chk({nm, " busy_at_done"}, busy, 1);
    chk({nm, " writes"}, writes, exp_w);
    chk({nm, " no_wrap"}, wrapped, 0);
    @(posedge clk); #1;
    chk({nm, " done_pulse"}, done, 0);
    chk({nm, " busy_clear"}, busy, 0);
    chk({nm, " frames"}, mon_q.size(), exp_q.size());
    for (int i = 0; i < mon_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s frame%0d", nm, i), mon_q[i], exp_q[i]);
    chk({nm, " sioc_edges"}, sioc_edges - e0,
        56 * exp_q.size());
  endtask

  typedef struct {
    logic [15:0] ent [4];
    int          exp_w;
    int          exp_lat;
    bit          extra;
    bit          chk_gap;
  } vec_t;

  vec_t vec [7];

  initial begin
    int nw;
    int lat;
    int k;
    logic [15:0] e;
    reset_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = 16'hFFFF;

    vec[0].ent = '{{OV_COM7, COM7_RESET}, 16'hF00A,
                   16'h1101, 16'hFFFF};
    vec[0].exp_w = 2;
    vec[0].exp_lat = 2 * (W + 2) + 10 * MS + 2 + 3;
    vec[0].extra = 0;
    vec[0].chk_gap = 1;
    vec[1] = '{'{16'hFFFF, 16'h0, 16'h0, 16'h0}, 0, 3, 0, 0};
    vec[2] = '{'{16'hF000, 16'hFFFF, 16'h0, 16'h0}, 0, 5, 0, 0};
    vec[3] = '{'{16'hF001, 16'h0A0B, 16'hFFFF, 16'h0}, 1,
               MS + 2 + W + 2 + 3, 0, 0};
    vec[4] = vec[0];
    vec[4].extra = 1;
    vec[4].chk_gap = 0;
    vec[5] = '{'{16'hFF00, 16'hFFFF, 16'h0, 16'h0}, 1,
               W + 2 + 3, 0, 0};
    vec[6] = '{'{16'h1234, 16'hFFFF, 16'h5678, 16'h9ABC}, 1,
               W + 2 + 3, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst rom_addr", rom_addr, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst writes", writes, 0);
    chk("rst sioc", sioc, 1);
    chk("rst siod_out", siod_out, 1);
    chk("rst siod_oe", siod_oe, 1);
    #1 reset_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 64; i++) rom[i] = 16'hFFFF;
      for (int i = 0; i < 4; i++) rom[i] = vec[v].ent[i];
      model(nw, lat);
      run_table($sformatf("vec%0d", v), vec[v].exp_w,
                vec[v].exp_lat, vec[v].extra);
      if (vec[v].chk_gap) begin
        chk("gap count", gap_q.size(), 1);
        if (gap_q.size() > 0)
          chk_rng("gap cycles", gap_q[0], 10 * MS,
                  10 * MS + 4 * Q + 10);
      end
    end

    // start during the done cycle is dropped; next cycle is taken
    for (int i = 0; i < 64; i++) rom[i] = 16'hFFFF;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while (!done && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("dc done", done, 1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("dc start_ignored", busy, 0);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("dc start_taken", busy, 1);
    k = 0;
    while (!done && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("dc second_done", done, 1);
    @(posedge clk);

    // async reset in the middle of a write
    rom[0] = 16'h1280;
    rom[1] = 16'h3456;
    rom[2] = 16'hFFFF;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while (!(mon_in && mon_bit == 13) && k < 2 * W) begin
      @(posedge clk);
      k++;
    end
    chk("rstmid reached_bit13", mon_bit, 13);
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    chk("rstmid sioc", sioc, 1);
    chk("rstmid siod_out", siod_out, 1);
    chk("rstmid busy", busy, 0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    model(nw, lat);
    run_table("restart", nw, lat, 0);

    // randomized tables against the model
    for (int r = 0; r < 8; r++) begin
      int n;
      for (int i = 0; i < 64; i++) rom[i] = 16'hFFFF;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 4) == 0) begin
          e = {8'hF0, 8'($urandom_range(0, 1))};
        end else begin
          e = 16'($urandom);
          if (e[15:8] == 8'hF0) e[15:8] = 8'h0F;
          if (e == 16'hFFFF) e = 16'hFFFE;
        end
        rom[i] = e;
      end
      model(nw, lat);
      run_table($sformatf("rand%0d", r), nw, lat, 0);
    end

    // no end marker: 64 writes then stop without wrapping
    for (int i = 0; i < 64; i++)
      rom[i] = {8'(8'h20 + i), 8'(i)};
    model(nw, lat);
    run_table("wrap64", 64, lat, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
